// File: rtl/wb_write_scheduler_pkg.sv
// Shared types and default widths for the write-back scheduler.
package wb_pkg;

   localparam int WB_AW = 5;
   localparam int WB_DW = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STROBE = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_write_scheduler_if.sv
// Producer handshakes plus register-file write ports of the scheduler.
// master = producers / register file side, slave = the scheduler.
interface wb_write_scheduler_if
   import wb_pkg::*;
#(
   parameter int AW = WB_AW,
   parameter int DW = WB_DW
);

   logic          in_valid_a;
   logic          in_ready_a;
   logic [AW-1:0] in_addr_a;
   logic [DW-1:0] in_data_a;

   logic          in_valid_b;
   logic          in_ready_b;
   logic [AW-1:0] in_addr_b;
   logic [DW-1:0] in_data_b;

   logic [AW-1:0] write_addr_1;
   logic [AW-1:0] write_addr_2;
   logic [DW-1:0] write_data_1;
   logic [DW-1:0] write_data_2;
   logic          write_enable_1;
   logic          write_enable_2;
   logic          busy;

   modport master (
      output in_valid_a, in_addr_a, in_data_a,
      output in_valid_b, in_addr_b, in_data_b,
      input  in_ready_a, in_ready_b,
      input  write_addr_1, write_addr_2, write_data_1, write_data_2,
      input  write_enable_1, write_enable_2, busy
   );

   modport slave (
      input  in_valid_a, in_addr_a, in_data_a,
      input  in_valid_b, in_addr_b, in_data_b,
      output in_ready_a, in_ready_b,
      output write_addr_1, write_addr_2, write_data_1, write_data_2,
      output write_enable_1, write_enable_2, busy
   );

endinterface

// File: rtl/wb_write_scheduler_fifo.sv
// In-order circular buffer with up to two pushes and two pops per cycle.
// Callers guarantee pushes never exceed free space and pops never exceed count.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int EW    = 69
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_a_i,
   input  logic [EW-1:0]          entry_a_i,
   input  logic                   push_b_i,
   input  logic [EW-1:0]          entry_b_i,
   input  logic [1:0]             pop_cnt_i,
   output logic [EW-1:0]          head0_o,
   output logic [EW-1:0]          head1_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_p1;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    n_push;

   assign wr_ptr_p1 = wr_ptr_q + PW'(1);
   assign rd_ptr_p1 = rd_ptr_q + PW'(1);
   assign head0_o   = mem_q[rd_ptr_q];
   assign head1_o   = mem_q[rd_ptr_p1];
   assign count_o   = count_q;

   // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
   always_comb begin
      n_push   = {1'b0, push_a_i} + {1'b0, push_b_i};
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
      count_d  = count_q + CW'(n_push) - CW'(pop_cnt_i);
   end

   // Storage write; A takes the older slot when both producers push.
   always_ff @(posedge clk) begin
      if (push_a_i) mem_q[wr_ptr_q] <= entry_a_i;
      if (push_b_i) mem_q[push_a_i ? wr_ptr_p1 : wr_ptr_q] <= entry_b_i;
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_write_scheduler.sv
// Write-back scheduler: queues producer results and drives the two
// edge-latched register-file write ports with a one-cycle setup window.
//
// state  | meaning
// IDLE   | enables low, nothing loaded; loads a pair as soon as queue is non-empty
// LOAD   | addr/data stable on the ports; enables rise on the next edge
// STROBE | enables high this cycle; next edge drops them and may load the next pair
module wb_write_scheduler
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   wb_write_scheduler_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        entry_a, entry_b, head0, head1;
   logic          push_a, push_b, ready_a, ready_b;
   logic [1:0]    pop_cnt;
   logic [CW-1:0] count;
   logic          pair_ok, do_load;

   wb_state_e     state_q, state_d;
   logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;
   logic          we1_q, we1_d, we2_q, we2_d;
   logic          use2_q, use2_d;

   // Ready looks only at registered occupancy so there is no valid->ready path.
   assign ready_a = (count <= CW'(DEPTH - 1));
   assign ready_b = (count <= CW'(DEPTH - 2));
   assign push_a  = bus.in_valid_a & ready_a;
   assign push_b  = bus.in_valid_b & ready_b;
   assign entry_a = {bus.in_addr_a, bus.in_data_a};
   assign entry_b = {bus.in_addr_b, bus.in_data_b};

   wb_fifo #(
      .DEPTH (DEPTH),
      .EW    ($bits(entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_a_i  (push_a),
      .entry_a_i (entry_a),
      .push_b_i  (push_b),
      .entry_b_i (entry_b),
      .pop_cnt_i (pop_cnt),
      .head0_o   (head0),
      .head1_o   (head1),
      .count_o   (count)
   );

   // Second slot is used only for a distinct address so same-address writes stay ordered.
   assign pair_ok = (count >= CW'(2)) && (head1.addr != head0.addr);

   // Next-state, pair formation and output next values.
   always_comb begin
      state_d = state_q;
      addr1_d = addr1_q;
      data1_d = data1_q;
      addr2_d = addr2_q;
      data2_d = data2_q;
      use2_d  = use2_q;
      we1_d   = 1'b0;
      we2_d   = 1'b0;
      pop_cnt = 2'd0;
      do_load = 1'b0;

      case (state_q)
         IDLE: begin
            if (count != '0) begin
               do_load = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            we1_d   = 1'b1;
            we2_d   = use2_q;
            state_d = STROBE;
         end
         STROBE: begin
            if (count != '0) begin
               do_load = 1'b1;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         addr1_d = head0.addr;
         data1_d = head0.data;
         use2_d  = pair_ok;
         pop_cnt = pair_ok ? 2'd2 : 2'd1;
         if (pair_ok) begin
            addr2_d = head1.addr;
            data2_d = head1.data;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr1_q <= '0;
         data1_q <= '0;
         addr2_q <= '0;
         data2_q <= '0;
         we1_q   <= 1'b0;
         we2_q   <= 1'b0;
         use2_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr1_q <= addr1_d;
         data1_q <= data1_d;
         addr2_q <= addr2_d;
         data2_q <= data2_d;
         we1_q   <= we1_d;
         we2_q   <= we2_d;
         use2_q  <= use2_d;
      end
   end

   assign bus.in_ready_a     = ready_a;
   assign bus.in_ready_b     = ready_b;
   assign bus.write_addr_1   = addr1_q;
   assign bus.write_data_1   = data1_q;
   assign bus.write_addr_2   = addr2_q;
   assign bus.write_data_2   = data2_q;
   assign bus.write_enable_1 = we1_q;
   assign bus.write_enable_2 = we2_q;
   assign bus.busy           = (count != '0) || (state_q != IDLE);

endmodule
